iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 8..64.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port in_valid  input  1  operation request valid.
REQ-005 Port in_ready  output  1  block can accept a request.
REQ-006 Port op  input  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MULU, 101 DIVU, 110/111 illegal.
REQ-007 Port a, b  input  WIDTH each  operands; b is divisor for DIVU.
REQ-008 Port out_valid  output  1  result valid.
REQ-009 Port out_ready  input  1  consumer accepts result.
REQ-010 Port res_lo  output  WIDTH  sum/difference/xor/slt, product low half, quotient.
REQ-011 Port res_hi  output  WIDTH  product high half, remainder; 0 for other ops.
REQ-012 Port flags  output  6  {err, div_zero, carry, overflow, negative, zero}, MSB first.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 Accept when in_valid and in_ready at a rising edge; a, b, op captured into internal registers at that edge; later input changes ignored.
REQ-015 ADD/SUB/XOR/SLT/illegal: IDLE -> DONE at accept edge; out_valid high the next cycle (latency 1).
REQ-016 MULU/DIVU: IDLE -> BUSY at accept; WIDTH iteration cycles counted by a log2(WIDTH)+1-bit counter; BUSY -> DONE after the WIDTH-th iteration; out_valid high WIDTH+1 cycles after accept.
REQ-017 MULU: unsigned shift-add, one multiplier bit per cycle; {res_hi,res_lo} = a*b exact 2*WIDTH bits.
REQ-018 DIVU: unsigned restoring division, one quotient bit per cycle; res_lo=a/b, res_hi=a%b.
REQ-019 DIVU with b=0: no iteration skip required; res_lo=all ones, res_hi=a, div_zero=1.
REQ-020 ADD: res_lo=(a+b) mod 2^WIDTH; carry=unsigned carry-out; overflow=signed overflow.
REQ-021 SUB: res_lo=(a-b) mod 2^WIDTH; carry=1 on unsigned borrow (a<b); overflow=signed overflow.
REQ-022 XOR: res_lo=a^b; carry=overflow=0.
REQ-023 SLT: res_lo=1 if signed a<b else 0, computed via sign of a-b xor overflow; carry=overflow=0.
REQ-024 negative=res_lo[WIDTH-1]; zero=1 iff res_lo=0, except MULU where zero=1 iff {res_hi,res_lo}=0.
REQ-025 Illegal op: res_lo=res_hi=0, err=1, other flags 0, latency 1.
REQ-026 DONE -> IDLE on edge with out_ready=1; while out_ready=0, res_lo, res_hi, flags held stable and out_valid stays 1.
REQ-027 No back-to-back accept in the DONE->IDLE cycle: next accept earliest one cycle after result handshake.
REQ-028 Outputs res_lo, res_hi, flags are registered; values outside DONE are unspecified-but-stable (hold last).

Reset
REQ-029 rst_n low forces immediately, independent of clk: state=IDLE, counter=0, res_lo=res_hi=0, flags=0, out_valid=0, in_ready=1 after release.
REQ-030 rst_n asserted during BUSY or DONE abandons the operation; no result is ever presented for it.
REQ-031 First accept possible on first rising edge with rst_n high.

Verification (WIDTH=32)
REQ-032 ADD a=0x7FFFFFFF b=1 -> next cycle out_valid, res_lo=0x80000000, overflow=1, negative=1, carry=0, zero=0.
REQ-033 SUB a=5 b=7 -> res_lo=0xFFFFFFFE, carry=1, negative=1; SLT a=0xFFFFFFFF b=1 -> res_lo=1.
REQ-034 MULU a=0xFFFFFFFF b=2 -> out_valid exactly 33 cycles after accept, res_hi=1, res_lo=0xFFFFFFFE; MULU a=0 b=5 -> zero=1.
REQ-035 DIVU a=100 b=7 -> res_lo=14, res_hi=2; DIVU a=100 b=0 -> res_lo=0xFFFFFFFF, res_hi=100, div_zero=1.
REQ-036 Result with out_ready low 5 cycles -> outputs stable, in_ready=0, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-037 rst_n low at cycle 10 of MULU -> all outputs 0 asynchronously, no out_valid; subsequent ADD 2+3 -> res_lo=5.

Source files
------------

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle add/sub/xor/slt, WIDTH-cycle shift-add
// multiply and restoring divide behind a valid/ready handshake.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [5:0]       flags
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       opr;
    logic [WIDTH-1:0] areg, breg, hi, lo;

    logic [WIDTH:0]   add_w, sub_w;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] fast_lo;
    logic [5:0]       fast_fl;
    logic             f_err, f_carry, f_ovf;

    assign add_w   = {1'b0, a} + {1'b0, b};
    assign sub_w   = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        fast_lo = '0;
        f_err   = 1'b0;
        f_carry = 1'b0;
        f_ovf   = 1'b0;
        unique case (op)
            3'b000: begin
                fast_lo = add_w[WIDTH-1:0];
                f_carry = add_w[WIDTH];
                f_ovf   = add_ovf;
            end
            3'b001: begin
                fast_lo = sub_w[WIDTH-1:0];
                f_carry = sub_w[WIDTH];
                f_ovf   = sub_ovf;
            end
            3'b010: fast_lo = a ^ b;
            3'b011: fast_lo = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
            default: f_err = 1'b1;
        endcase
        if (f_err)
            fast_fl = 6'b100000;
        else
            fast_fl = {2'b00, f_carry, f_ovf, fast_lo[WIDTH-1], fast_lo == '0};
    end

    // hi/lo hold {accumulator, multiplier} for MULU, {remainder, dividend/quotient} for DIVU
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH+1:0] div_df;
    logic [WIDTH-1:0] nx_hi, nx_lo;
    logic [5:0]       it_fl;
    logic             unused_bits;

    assign mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, areg} : '0);
    assign div_sh      = {hi, lo[WIDTH-1]};
    assign div_df      = {1'b0, div_sh} - {2'b00, breg};
    assign unused_bits = ^{div_sh[WIDTH], div_df[WIDTH]};

    always_comb begin
        if (opr == 3'b100) begin
            nx_hi = mul_sum[WIDTH:1];
            nx_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (!div_df[WIDTH+1]) begin
            nx_hi = div_df[WIDTH-1:0];
            nx_lo = {lo[WIDTH-2:0], 1'b1};
        end else begin
            nx_hi = div_sh[WIDTH-1:0];
            nx_lo = {lo[WIDTH-2:0], 1'b0};
        end
        if (opr == 3'b100)
            it_fl = {4'b0000, nx_lo[WIDTH-1], {nx_hi, nx_lo} == '0};
        else
            it_fl = {1'b0, breg == '0, 2'b00, nx_lo[WIDTH-1], nx_lo == '0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opr       <= '0;
            areg      <= '0;
            breg      <= '0;
            hi        <= '0;
            lo        <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            flags     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opr      <= op;
                        areg     <= a;
                        breg     <= b;
                        cnt      <= '0;
                        hi       <= '0;
                        lo       <= (op == 3'b100) ? b : a;
                        in_ready <= 1'b0;
                        if (op == 3'b100 || op == 3'b101) begin
                            state <= BUSY;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            res_lo    <= fast_lo;
                            res_hi    <= '0;
                            flags     <= fast_fl;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    hi  <= nx_hi;
                    lo  <= nx_lo;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res_lo    <= nx_lo;
                        res_hi    <= nx_hi;
                        flags     <= it_fl;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32): directed table,
// handshake/reset sequences and randomized ops against a reference model.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res_lo, res_hi;
    logic [5:0]  flags;

    int checks = 0;
    int failures = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [5:0]  fl;
    } res_t;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [5:0]  fl;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t r;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s = 0;
        logic [63:0] p = '0;
        logic c = 1'b0, v = 1'b0, dz = 1'b0, z;
        r.lo = '0;
        r.hi = '0;
        case (o)
            3'd0: begin
                p = 64'(x) + 64'(y);
                r.lo = p[31:0];
                c = x > 32'hFFFF_FFFF - y;
                s = sx + sy;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'd1: begin
                r.lo = x - y;
                c = x < y;
                s = sx - sy;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'd2: r.lo = x ^ y;
            3'd3: r.lo = (sx < sy) ? 32'd1 : 32'd0;
            3'd4: begin
                p = 64'(x) * 64'(y);
                r.lo = p[31:0];
                r.hi = p[63:32];
            end
            3'd5: begin
                if (y == 0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = x;
                    dz = 1'b1;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
            default: begin
                r.fl = 6'b100000;
                return r;
            end
        endcase
        z = (o == 3'd4) ? ({r.hi, r.lo} == 64'd0) : (r.lo == 32'd0);
        r.fl = {1'b0, dz, c, v, r.lo[31], z};
        return r;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output res_t r, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r.lo = res_lo;
        r.hi = res_hi;
        r.fl = flags;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[$];
    res_t got, exp;
    int   lat;
    logic seen;

    initial begin
        vecs.push_back('{3'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 6'b000110, 1});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 6'b001001, 1});
        vecs.push_back('{3'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0, 6'b001010, 1});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 6'b000000, 1});
        vecs.push_back('{3'd2, 32'h0000_F0F0, 32'h0000_F0F0, 32'd0, 32'd0, 6'b000001, 1});
        vecs.push_back('{3'd4, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 6'b000010, 33});
        vecs.push_back('{3'd4, 32'd0, 32'd5, 32'd0, 32'd0, 6'b000001, 33});
        vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 32'd2, 6'b000000, 33});
        vecs.push_back('{3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 6'b010010, 33});
        vecs.push_back('{3'd6, 32'd9, 32'd4, 32'd0, 32'd0, 6'b100000, 1});

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_res_lo", 64'(res_lo), 64'd0);
        chk("reset_res_hi", 64'(res_hi), 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, got, lat);
            chk($sformatf("vec%0d_lo", i), 64'(got.lo), 64'(vecs[i].lo));
            chk($sformatf("vec%0d_hi", i), 64'(got.hi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d_flags", i), 64'(got.fl), 64'(vecs[i].fl));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // result held while consumer stalls; new requests ignored meanwhile
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd0;
        a = 32'd2;
        b = 32'd3;
        @(posedge clk);
        #1;
        chk("stall_first_valid", 64'(out_valid), 64'd1);
        op = 3'd1;
        a = 32'd40;
        b = 32'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_res_lo", 64'(res_lo), 64'd5);
            chk("stall_flags", 64'(flags), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handshake_valid_drop", 64'(out_valid), 64'd0);
        chk("handshake_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("no_b2b_accept", 64'(out_valid), 64'd0);
        chk("no_b2b_in_ready", 64'(in_ready), 64'd1);

        // reset mid-multiply abandons the operation
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'd4;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_lo", 64'(res_lo), 64'd0);
        chk("async_rst_hi", 64'(res_hi), 64'd0);
        chk("async_rst_flags", 64'(flags), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abandoned_no_result", 64'(seen), 64'd0);
        run_op(3'd0, 32'd2, 32'd3, got, lat);
        chk("post_reset_add", 64'(got.lo), 64'd5);

        for (int n = 0; n < 150; n++) begin
            logic [2:0]  ro;
            logic [31:0] rx, ry;
            ro = 3'($urandom_range(0, 7));
            rx = (n % 5 == 0) ? 32'h8000_0000 | $urandom : $urandom;
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            exp = model(ro, rx, ry);
            run_op(ro, rx, ry, got, lat);
            chk($sformatf("rand%0d_op%0d_lo", n, ro), 64'(got.lo), 64'(exp.lo));
            chk($sformatf("rand%0d_op%0d_hi", n, ro), 64'(got.hi), 64'(exp.hi));
            chk($sformatf("rand%0d_op%0d_flags", n, ro), 64'(got.fl), 64'(exp.fl));
            chk($sformatf("rand%0d_op%0d_lat", n, ro), 64'(lat),
                (ro == 3'd4 || ro == 3'd5) ? 64'd33 : 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
